// File: rtl/hqm_AW_pkg.sv
// Shared types for the assertion RAM read-modify-write block:
// op encoding, FSM states and the AW_logb2 address-width helper.
package hqm_AW_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_ADD   = 2'b10,
    OP_SUB   = 2'b11
  } rmw_op_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rmw_state_e;

  // Index of the highest set bit (0 for inputs 0 and 1).
  function automatic int AW_logb2(input int unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/hqm_assertion_ram_rmw_if.sv
// Request/response bundle of the RMW block.
// master: requester side; slave: RMW engine side.
interface hqm_assertion_ram_rmw_if #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 16
);
  import hqm_AW_pkg::*;

  logic              req_v;
  logic              req_ready;
  logic [OP_W-1:0]   req_op;
  logic [AWIDTH-1:0] req_addr;
  logic [DWIDTH-1:0] req_data;
  logic              rsp_v;
  logic [DWIDTH-1:0] rsp_old;
  logic [DWIDTH-1:0] rsp_new;

  modport master (
    output req_v, req_op, req_addr, req_data,
    input  req_ready, rsp_v, rsp_old, rsp_new
  );

  modport slave (
    input  req_v, req_op, req_addr, req_data,
    output req_ready, rsp_v, rsp_old, rsp_new
  );

endinterface

// File: rtl/hqm_assertion_ram_rmw.sv
// Zero-initialising read-modify-write engine over an external 1-cycle RAM.
// Ports: clk/rst_n, rmw (req/rsp bundle), ram read/write ports, init_done, err_v.
module hqm_assertion_ram_rmw
  import hqm_AW_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DWIDTH = 16,
  parameter int AWIDTH = AW_logb2(DEPTH-1)+1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hqm_assertion_ram_rmw_if.slave rmw,
  output logic                  ram_re,
  output logic [AWIDTH-1:0]     ram_raddr,
  input  logic [DWIDTH-1:0]     ram_rdata,
  input  logic                  ram_rdata_v,
  output logic                  ram_we,
  output logic [AWIDTH-1:0]     ram_waddr,
  output logic [DWIDTH-1:0]     ram_wdata,
  output logic                  init_done,
  output logic                  err_v
);

  localparam logic [AWIDTH-1:0] LAST = AWIDTH'(DEPTH-1);

  rmw_state_e        state_q;
  rmw_state_e        state_d;
  logic [AWIDTH-1:0] cnt_q;
  logic [AWIDTH-1:0] cnt_d;

  logic              s1_v;
  rmw_op_e           s1_op;
  logic [AWIDTH-1:0] s1_addr;
  logic [DWIDTH-1:0] s1_data;

  logic              lw_v;
  logic [AWIDTH-1:0] lw_addr;
  logic [DWIDTH-1:0] lw_data;

  logic              acc;
  logic              s1_wr;
  logic [DWIDTH-1:0] old;
  logic [DWIDTH-1:0] nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rmw.req_ready = 1'b0;
    ram_we        = 1'b0;
    ram_waddr     = s1_addr;
    ram_wdata     = nxt;
    unique case (state_q)
      ST_INIT: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q;
        ram_wdata = '0;
        cnt_d     = cnt_q + AWIDTH'(1);
        if (cnt_q == LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        rmw.req_ready = 1'b1;
        ram_we        = s1_wr;
      end
      default: ;
    endcase
  end

  assign acc       = rmw.req_v & rmw.req_ready;
  assign ram_re    = acc;
  assign ram_raddr = rmw.req_addr;

  // Most recent write may not be visible in the RAM return yet.
  assign old = (lw_v && lw_addr == s1_addr) ? lw_data : ram_rdata;

  always_comb begin
    nxt = old;
    unique case (s1_op)
      OP_READ:  nxt = old;
      OP_WRITE: nxt = s1_data;
      OP_ADD:   nxt = old + s1_data;
      OP_SUB:   nxt = (old > s1_data) ? old - s1_data : '0;
      default:  nxt = old;
    endcase
  end

  assign s1_wr = s1_v & (s1_op != OP_READ);
  assign err_v = s1_v ^ ram_rdata_v;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v    <= 1'b0;
      s1_op   <= OP_READ;
      s1_addr <= '0;
      s1_data <= '0;
    end else begin
      s1_v <= acc;
      if (acc) begin
        s1_op   <= rmw_op_e'(rmw.req_op);
        s1_addr <= rmw.req_addr;
        s1_data <= rmw.req_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lw_v    <= 1'b0;
      lw_addr <= '0;
      lw_data <= '0;
    end else if (s1_wr) begin
      lw_v    <= 1'b1;
      lw_addr <= s1_addr;
      lw_data <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rmw.rsp_v   <= 1'b0;
      rmw.rsp_old <= '0;
      rmw.rsp_new <= '0;
      init_done   <= 1'b0;
    end else begin
      rmw.rsp_v <= s1_v;
      if (s1_v) begin
        rmw.rsp_old <= old;
        rmw.rsp_new <= nxt;
      end
      init_done <= (state_q == ST_RUN);
    end
  end

endmodule

// File: tb/tb_hqm_assertion_ram_rmw.sv
// Bench for hqm_assertion_ram_rmw: behavioural RAM, array reference model,
// directed scenarios then randomized traffic, reset mid-operation.
module tb_hqm_assertion_ram_rmw;
  import hqm_AW_pkg::*;

  localparam int DEPTH = 8;
  localparam int DW    = 16;
  localparam int AW    = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hqm_assertion_ram_rmw_if #(.AWIDTH(AW), .DWIDTH(DW)) rmw();

  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rdata;
  logic          ram_rdata_v;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic          init_done;
  logic          err_v;

  hqm_assertion_ram_rmw #(.DEPTH(DEPTH), .DWIDTH(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rmw         (rmw),
    .ram_re      (ram_re),
    .ram_raddr   (ram_raddr),
    .ram_rdata   (ram_rdata),
    .ram_rdata_v (ram_rdata_v),
    .ram_we      (ram_we),
    .ram_waddr   (ram_waddr),
    .ram_wdata   (ram_wdata),
    .init_done   (init_done),
    .err_v       (err_v)
  );

  logic [DW-1:0] mem [DEPTH];
  logic          drop = 1'b0;

  always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_rdata_v <= 1'b0;
      ram_rdata   <= '0;
    end else begin
      ram_rdata_v <= ram_re & ~drop;
      if (ram_re) ram_rdata <= mem[ram_raddr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            cyc;
    logic [DW-1:0] o;
    logic [DW-1:0] n;
  } exp_t;

  exp_t          exp_q[$];
  int            err_q[$];
  logic [DW-1:0] ref_mem [DEPTH];
  int            n_vec = 0;
  int            n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h @cyc %0d",
               tag, got, want, cyc);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      if (rmw.rsp_v) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("rsp_latency", cyc, mon_e.cyc);
          chk("rsp_old", rmw.rsp_old, mon_e.o);
          chk("rsp_new", rmw.rsp_new, mon_e.n);
        end
      end
      if (err_v) begin
        if (err_q.size() == 0) chk("err_unexpected", 1, 0);
        else chk("err_cycle", cyc, err_q.pop_front());
      end
    end
  end

  task automatic issue(input logic [1:0] op, input int addr,
                       input logic [DW-1:0] d, input bit drp);
    exp_t          e;
    logic [DW-1:0] o;
    logic [DW-1:0] n;
    chk("req_ready", rmw.req_ready, 1);
    o = ref_mem[addr];
    case (op)
      2'd0:    n = o;
      2'd1:    n = d;
      2'd2:    n = o + d;
      default: n = (o > d) ? o - d : '0;
    endcase
    if (op != 2'd0) ref_mem[addr] = n;
    e.cyc = cyc + 2;
    e.o   = o;
    e.n   = n;
    exp_q.push_back(e);
    if (drp) err_q.push_back(cyc + 1);
    rmw.req_v    = 1'b1;
    rmw.req_op   = op;
    rmw.req_addr = addr[AW-1:0];
    rmw.req_data = d;
    drop         = drp;
    @(posedge clk);
    #1;
    rmw.req_v = 1'b0;
    drop      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Entered at a falling edge with rst_n low.
  task automatic init_sweep();
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("init_we", ram_we, 1);
      chk("init_waddr", ram_waddr, i);
      chk("init_wdata", ram_wdata, 0);
      chk("init_ready", rmw.req_ready, 0);
      chk("init_re", ram_re, 0);
      @(negedge clk);
    end
    chk("init_done_c8", init_done, 0);
    chk("run_ready", rmw.req_ready, 1);
    @(negedge clk);
    chk("init_done_c9", init_done, 1);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    idle(4);
    chk({tag, "_rsp_left"}, exp_q.size(), 0);
    chk({tag, "_err_left"}, err_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [1:0]    r_op;
    int            r_addr;
    logic [DW-1:0] r_dat;
    bit            r_drp;
    rmw.req_v    = 1'b0;
    rmw.req_op   = '0;
    rmw.req_addr = '0;
    rmw.req_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_rsp_v", rmw.rsp_v, 0);
    chk("rst_rsp_old", rmw.rsp_old, 0);
    chk("rst_rsp_new", rmw.rsp_new, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_err_v", err_v, 0);
    init_sweep();

    issue(2'd1, 3, 16'h1234, 0);
    idle(1);
    issue(2'd0, 3, 16'h0000, 0);
    idle(3);
    issue(2'd2, 5, 16'h0001, 0);
    issue(2'd2, 5, 16'h0001, 0);
    issue(2'd2, 5, 16'h0001, 0);
    issue(2'd1, 2, 16'h0005, 0);
    issue(2'd3, 2, 16'h0009, 0);
    issue(2'd1, 1, 16'hFFFF, 0);
    issue(2'd2, 1, 16'h0001, 0);
    issue(2'd0, 4, 16'h0000, 1);
    issue(2'd0, 3, 16'h0000, 0);
    issue(2'd2, 5, 16'h0000, 0);
    drain("dir");
    chk("ram_e5", mem[5], 3);
    chk("ram_e1", mem[1], 0);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else begin
        r_op   = 2'($urandom_range(0, 3));
        r_addr = int'($urandom_range(0, DEPTH-1));
        case ($urandom_range(0, 3))
          0:       r_dat = 16'hFFFF;
          1:       r_dat = 16'h0000;
          default: r_dat = DW'($urandom);
        endcase
        r_drp = ($urandom_range(0, 15) == 0);
        issue(r_op, r_addr, r_dat, r_drp);
      end
    end
    drain("rnd");
    for (int i = 0; i < DEPTH; i++) chk("ram_final", mem[i], ref_mem[i]);

    issue(2'd2, 6, 16'h0007, 0);
    rst_n = 1'b0;
    exp_q.delete();
    err_q.delete();
    @(negedge clk);
    chk("midrst_rsp_v", rmw.rsp_v, 0);
    chk("midrst_done", init_done, 0);
    @(negedge clk);
    init_sweep();
    issue(2'd0, 6, 16'h0000, 0);
    issue(2'd2, 6, 16'h0003, 0);
    issue(2'd3, 6, 16'h0001, 0);
    drain("post");
    chk("ram_e6", mem[6], 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
